// File: rtl/adder_pkg.sv
// Shared constants and configuration check for the pipelined add/subtract unit.
package adder_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;

    // Every stage must own an equal, non-empty slice of the carry chain.
    function automatic bit cfg_ok(int width, int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
interface pipelined_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sout;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, Sout, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, Sout, Cout, Ovf
    );

endinterface

// File: rtl/adder_slice.sv
// Combinational ripple-carry add of one SLICE-bit piece of the carry chain.
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: carry chain split into STAGES slices with a stall-all
// valid/ready pipeline, carry-out and signed-overflow flags.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic              clk,
    input  logic              reset,
    pipelined_adder_if.slave  bus
);

    localparam int SL = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic [STAGES:0]              vld_pipe;
    // Word carrying A, with every already-added slice replaced by its sum bits.
    logic [STAGES:0][WIDTH-1:0]   w_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES:0]              c_q;
    logic                         ovf_q;
    logic                         stall;

    logic [STAGES-1:0][SL-1:0]    sum_w;
    logic [STAGES-1:0]            co_w;
    logic [STAGES-1:0]            cm_w;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(.SLICE(SL)) u_slice (
            .a     (w_q[k][k*SL +: SL]),
            .b     (b_q[k][k*SL +: SL]),
            .ci    (c_q[k]),
            .s     (sum_w[k]),
            .co    (co_w[k]),
            .c_msb (cm_w[k])
        );
    end

    // Only the top slice's MSB carry feeds Ovf, and the last B register only
    // needs its top slice; the remaining bits are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{cm_w, b_q[STAGES-1]};

    assign stall         = vld_pipe[STAGES] && !bus.out_ready;
    assign bus.in_ready  = !stall && !reset;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.Sout      = w_q[STAGES];
    assign bus.Cout      = c_q[STAGES];
    assign bus.Ovf       = ovf_q;

    // The whole pipeline, bubbles included, freezes on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            w_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
            w_q[0]   <= bus.A;
            b_q[0]   <= bus.sub ? ~bus.B : bus.B;
            c_q[0]   <= bus.sub | bus.Cin;
            for (int k = 1; k <= STAGES; k++) begin
                w_q[k]                  <= w_q[k-1];
                w_q[k][(k-1)*SL +: SL]  <= sum_w[k-1];
                c_q[k]                  <= co_w[k-1];
            end
            for (int k = 1; k < STAGES; k++) begin
                b_q[k] <= b_q[k-1];
            end
            ovf_q <= co_w[STAGES-1] ^ cm_w[STAGES-1];
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: 8-bit/2-stage unit with directed cases, plus random traffic on
// (32,4), (16,1) and (8,8) instances sharing the clock and reset.
module tb_pipelined_adder;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   go = 1'b0;
    bit   lat_chk = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: sign rule for overflow (operands agree in sign, result differs).
    function automatic sb_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub, input int t);
        sb_t         r;
        logic [63:0] mask, bp;
        logic [64:0] full;
        mask  = (64'd1 << w) - 64'd1;
        bp    = sub ? (~b & mask) : (b & mask);
        full  = {1'b0, a & mask} + {1'b0, bp} + {64'd0, (sub ? 1'b1 : cin)};
        r.s   = full[63:0] & mask;
        r.c   = full[w];
        r.o   = (a[w-1] == bp[w-1]) && (r.s[w-1] != a[w-1]);
        r.cyc = t;
        return r;
    endfunction

    // ---------------- main 8-bit / 2-stage instance ----------------
    localparam int W0 = 8;
    localparam int S0 = 2;

    pipelined_adder_if #(.WIDTH(W0)) mif ();
    pipelined_adder #(.WIDTH(W0), .STAGES(S0)) u_dut (.clk(clk), .reset(reset), .bus(mif));

    sb_t        sbq[$];
    int         n_out = 0;
    logic [7:0] last_s;
    logic       last_c, last_o;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_s;
    logic       prev_c, prev_o;

    always @(negedge clk) begin
        sb_t e;
        if (reset) begin
            sbq.delete();
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_sout", mif.Sout, prev_s);
                chk("hold_cout", mif.Cout, prev_c);
                chk("hold_ovf",  mif.Ovf,  prev_o);
            end
            if (mif.out_valid && !mif.out_ready) chk("stall_in_ready", mif.in_ready, 1'b0);
            if (mif.out_valid && mif.out_ready) begin
                if (sbq.size() == 0) chk("unexpected_out", 1'b1, 1'b0);
                else begin
                    e = sbq.pop_front();
                    chk("sout", mif.Sout, e.s);
                    chk("cout", mif.Cout, e.c);
                    chk("ovf",  mif.Ovf,  e.o);
                    if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(S0 + 1));
                    last_s <= mif.Sout;
                    last_c <= mif.Cout;
                    last_o <= mif.Ovf;
                    n_out  <= n_out + 1;
                end
            end
            if (mif.in_valid && mif.in_ready)
                sbq.push_back(model(W0, 64'(mif.A), 64'(mif.B), mif.Cin, mif.sub, cyc));
            prev_stall <= mif.out_valid && !mif.out_ready;
            prev_s     <= mif.Sout;
            prev_c     <= mif.Cout;
            prev_o     <= mif.Ovf;
        end
    end

    // Presents one beat and returns just after the edge that accepts it; in_valid stays high.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sb);
        bit ok = 1'b0;
        mif.A = a; mif.B = b; mif.Cin = cin; mif.sub = sb; mif.in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (mif.in_ready) begin ok = 1'b1; break; end
        end
        chk("accept", ok, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 64'(sbq.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sb,
                          input logic [7:0] es, input logic ec, input logic eo);
        send(a, b, cin, sb);
        mif.in_valid = 1'b0;
        drain();
        chk({tag, "_s"}, last_s, es);
        chk({tag, "_c"}, last_c, ec);
        chk({tag, "_o"}, last_o, eo);
    endtask

    initial begin
        int n0;
        bit all_done;
        reset = 1'b1;
        mif.in_valid = 1'b1; mif.A = 8'h5A; mif.B = 8'hA5; mif.Cin = 1'b1; mif.sub = 1'b0;
        mif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", mif.out_valid, 1'b0);
        chk("rst_sout",      mif.Sout,      8'h00);
        chk("rst_cout",      mif.Cout,      1'b0);
        chk("rst_ovf",       mif.Ovf,       1'b0);
        chk("rst_in_ready",  mif.in_ready,  1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        mif.in_valid = 1'b0;
        go = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", mif.in_ready, 1'b1);
        @(posedge clk); #1;

        lat_chk = 1'b1;
        single("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        single("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        single("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        single("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Back-to-back: per-beat latency of STAGES+1 with consecutive accepts
        // implies consecutive results.
        n0 = n_out;
        for (int i = 0; i < 16; i++)
            send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        mif.in_valid = 1'b0;
        drain();
        chk("b2b_count", 64'(n_out - n0), 64'd16);
        lat_chk = 1'b0;

        // Backpressure mid-stream, with occasional bubbles.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    if (($urandom % 4) == 0) begin
                        mif.in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
                end
                mif.in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 mif.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 mif.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 64'(n_out - n0), 64'd20);

        // Reset with three beats held in flight.
        mif.out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b0, 1'b1);
        send(8'h55, 8'h66, 1'b1, 1'b0);
        mif.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mif.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_valid", mif.out_valid, 1'b0);
        end
        @(posedge clk); #1;
        single("post_rst", 8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1);

        all_done = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            all_done = g_rnd[0].done_r && g_rnd[1].done_r && g_rnd[2].done_r;
            if (all_done) break;
            @(posedge clk);
        end
        chk("random_done", all_done, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- random traffic on other configurations ----------------
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int W = (g == 0) ? 32 : ((g == 1) ? 16 : 8);
        localparam int S = (g == 0) ? 4  : ((g == 1) ? 1  : 8);

        pipelined_adder_if #(.WIDTH(W)) rif ();
        pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .reset(reset), .bus(rif));

        sb_t q[$];
        bit  done_r = 1'b0;

        always @(negedge clk) begin
            sb_t e;
            if (reset) q.delete();
            else begin
                if (rif.out_valid && rif.out_ready) begin
                    if (q.size() == 0) chk($sformatf("w%0d_unexpected", W), 1'b1, 1'b0);
                    else begin
                        e = q.pop_front();
                        chk($sformatf("w%0d_sout", W), 64'(rif.Sout), e.s);
                        chk($sformatf("w%0d_cout", W), rif.Cout, e.c);
                        chk($sformatf("w%0d_ovf",  W), rif.Ovf,  e.o);
                    end
                end
                if (rif.in_valid && rif.in_ready)
                    q.push_back(model(W, 64'(rif.A), 64'(rif.B), rif.Cin, rif.sub, cyc));
            end
        end

        initial begin
            logic [31:0] ra, rb;
            rif.in_valid = 1'b0; rif.out_ready = 1'b1;
            rif.A = '0; rif.B = '0; rif.Cin = 1'b0; rif.sub = 1'b0;
            wait (go);
            for (int t = 0; t < 300; t++) begin
                @(posedge clk); #1;
                ra = $urandom; rb = $urandom;
                rif.A         = ra[W-1:0];
                rif.B         = rb[W-1:0];
                rif.Cin       = 1'($urandom);
                rif.sub       = 1'($urandom);
                rif.in_valid  = ($urandom % 4) != 0;
                rif.out_ready = ($urandom % 4) != 0;
            end
            @(posedge clk); #1;
            rif.in_valid  = 1'b0;
            rif.out_ready = 1'b1;
            for (int t = 0; t < 100; t++) begin
                if (q.size() == 0) break;
                @(negedge clk);
            end
            chk($sformatf("w%0d_drain", W), 64'(q.size()), 64'd0);
            done_r = 1'b1;
        end
    end

endmodule
